// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - dual-producer writeback FIFO draining into the register unit
// Optional WB_FORWARD_EN adds youngest-match data forwarding on SR1_FWD/SR2_FWD.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [2:0]    alu_dr,
  input  logic [15:0]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [2:0]    mem_dr,
  input  logic [15:0]   mem_data,
  input  logic          wb_stall,
  output logic [15:0]   wb_bus,
  output logic [2:0]    wb_dr,
  output logic          LD_REG,
  input  logic [2:0]    SR1_IDX,
  input  logic [2:0]    SR2_IDX,
  output logic          SR1_PEND,
  output logic          SR2_PEND,
  output logic [15:0]   SR1_FWD,
  output logic [15:0]   SR2_FWD,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    dr_q   [DEPTH];
  logic [2:0]    dr_d   [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, free;
  logic          alu_acc, mem_acc, pop;
  logic [PW-1:0] scan_idx;

  // Readiness ignores a same-cycle pop so it never depends on wb_stall.
  assign free      = CW'(DEPTH) - count_q;
  assign alu_ready = (free != '0);
  assign mem_ready = (free >= CW'(2)) || ((free != '0) && !alu_valid);
  assign alu_acc   = alu_valid && alu_ready;
  assign mem_acc   = mem_valid && mem_ready;

  assign LD_REG = (count_q != '0) && !wb_stall;
  assign pop    = LD_REG;
  assign wb_bus = (count_q != '0) ? data_q[head_q] : '0;
  assign wb_dr  = (count_q != '0) ? dr_q[head_q] : '0;
  assign count  = count_q;

  always_comb begin
    dr_d   = dr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q + PW'(alu_acc) + PW'(mem_acc);
    if (alu_acc) begin
      dr_d[tail_q]   = alu_dr;
      data_d[tail_q] = alu_data;
    end
    // The ALU entry is older, so memory lands one slot behind it.
    if (mem_acc) begin
      dr_d[tail_q + PW'(alu_acc)]   = mem_dr;
      data_d[tail_q + PW'(alu_acc)] = mem_data;
    end
    if (pop) head_d = head_q + PW'(1);
    count_d = count_q + CW'(alu_acc) + CW'(mem_acc) - CW'(pop);
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    SR1_PEND = 1'b0;
    SR2_PEND = 1'b0;
    SR1_FWD  = '0;
    SR2_FWD  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (dr_q[scan_idx] == SR1_IDX) begin
          SR1_PEND = 1'b1;
`ifdef WB_FORWARD_EN
          SR1_FWD  = data_q[scan_idx];
`endif
        end
        if (dr_q[scan_idx] == SR2_IDX) begin
          SR2_PEND = 1'b1;
`ifdef WB_FORWARD_EN
          SR2_FWD  = data_q[scan_idx];
`endif
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge Clk) begin
    dr_q   <= dr_d;
    data_q <= data_d;
  end

endmodule
